// File: rtl/h14tx_timings_if.sv
// Video timing bundle from the HDMI 1.4 TX timing generator to the TMDS encoder stages.
// Island signals exist only when H14TX_TIMINGS_DI_EN is defined.
interface h14tx_timings_if #(
  parameter int unsigned XW = 11,
  parameter int unsigned YW = 10
);
  logic          hsync;
  logic          vsync;
  logic          de;
  logic [XW-1:0] x;
  logic [YW-1:0] y;
  logic          vid_preamble;
  logic          vid_guard;
  logic          frame_start;
`ifdef H14TX_TIMINGS_DI_EN
  logic          island_preamble;
  logic          island_guard;
  logic          island_data;
`endif

  modport master (
    output hsync, vsync, de, x, y, vid_preamble, vid_guard, frame_start
`ifdef H14TX_TIMINGS_DI_EN
    , output island_preamble, island_guard, island_data
`endif
  );

  modport slave (
    input hsync, vsync, de, x, y, vid_preamble, vid_guard, frame_start
`ifdef H14TX_TIMINGS_DI_EN
    , input island_preamble, island_guard, island_data
`endif
  );
endinterface

// File: rtl/h14tx_timings.sv
// HDMI 1.4 TX video timing generator: syncs, DE, pixel coordinates, video preamble/guard windows.
// Optional data-island windows are enabled by defining H14TX_TIMINGS_DI_EN.
module h14tx_timings #(
  parameter int unsigned HActive     = 1280,
  parameter int unsigned HFrontPorch = 110,
  parameter int unsigned HSync       = 40,
  parameter int unsigned HBackPorch  = 220,
  parameter int unsigned VActive     = 720,
  parameter int unsigned VFrontPorch = 5,
  parameter int unsigned VSync       = 5,
  parameter int unsigned VBackPorch  = 20,
  parameter bit          HSyncPol    = 1'b1,
  parameter bit          VSyncPol    = 1'b1
) (
  input  logic           pixel_clk,
  input  logic           rst_n,
  h14tx_timings_if.master vid
);

  localparam int unsigned HBlank     = HFrontPorch + HSync + HBackPorch;
  localparam int unsigned HTotal     = HActive + HBlank;
  localparam int unsigned VTotal     = VActive + VFrontPorch + VSync + VBackPorch;
  localparam int unsigned HCW        = (HTotal > 1) ? $clog2(HTotal) : 1;
  localparam int unsigned VCW        = (VTotal > 1) ? $clog2(VTotal) : 1;
  localparam int unsigned XW         = (HActive > 1) ? $clog2(HActive) : 1;
  localparam int unsigned YW         = (VActive > 1) ? $clog2(VActive) : 1;
  localparam int unsigned HSyncStart = HActive + HFrontPorch;
  localparam int unsigned HSyncEnd   = HSyncStart + HSync - 1;
  localparam int unsigned VSyncStart = VActive + VFrontPorch;
  localparam int unsigned VSyncEnd   = VSyncStart + VSync - 1;
  localparam int unsigned PreStart   = HTotal - 10;
  localparam int unsigned PreEnd     = HTotal - 3;
  localparam int unsigned GuardStart = HTotal - 2;

  if (HActive < 1 || HFrontPorch < 1 || HSync < 1 || HBackPorch < 1 ||
      VActive < 1 || VFrontPorch < 1 || VSync < 1 || VBackPorch < 1) begin : g_bad_param
    $error("h14tx_timings: every timing parameter must be at least 1");
  end
  // Blank must hold 4 control + 8 preamble + 2 guard periods.
  if (HBlank < 14) begin : g_bad_hblank
    $error("h14tx_timings: horizontal blank shorter than 14 pixels");
  end

  logic [HCW-1:0] r_h_cnt;
  logic [VCW-1:0] r_v_cnt;

  // Raster counters; origin (0,0) is the first active pixel of a frame.
  always_ff @(posedge pixel_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_h_cnt <= '0;
      r_v_cnt <= '0;
    end else if (r_h_cnt == HCW'(HTotal - 1)) begin
      r_h_cnt <= '0;
      r_v_cnt <= (r_v_cnt == VCW'(VTotal - 1)) ? '0 : r_v_cnt + VCW'(1);
    end else begin
      r_h_cnt <= r_h_cnt + HCW'(1);
    end
  end

  logic w_de;
  logic w_hsync_on;
  logic w_vsync_on;
  logic w_next_active;
  logic w_preamble;
  logic w_guard;
  logic w_frame_start;

  assign w_de          = (r_h_cnt < HCW'(HActive)) && (r_v_cnt < VCW'(VActive));
  assign w_hsync_on    = (r_h_cnt >= HCW'(HSyncStart)) && (r_h_cnt <= HCW'(HSyncEnd));
  assign w_vsync_on    = (r_v_cnt >= VCW'(VSyncStart)) && (r_v_cnt <= VCW'(VSyncEnd));
  // Last line wraps to line 0, which is always active.
  assign w_next_active = (r_v_cnt == VCW'(VTotal - 1)) ||
                         ((r_v_cnt + VCW'(1)) < VCW'(VActive));
  assign w_preamble    = (r_h_cnt >= HCW'(PreStart)) && (r_h_cnt <= HCW'(PreEnd)) && w_next_active;
  assign w_guard       = (r_h_cnt >= HCW'(GuardStart)) && w_next_active;
  assign w_frame_start = (r_h_cnt == '0) && (r_v_cnt == '0);

  logic          r_hsync;
  logic          r_vsync;
  logic          r_de;
  logic [XW-1:0] r_x;
  logic [YW-1:0] r_y;
  logic          r_preamble;
  logic          r_guard;
  logic          r_frame_start;

  always_ff @(posedge pixel_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hsync       <= ~HSyncPol;
      r_vsync       <= ~VSyncPol;
      r_de          <= 1'b0;
      r_x           <= '0;
      r_y           <= '0;
      r_preamble    <= 1'b0;
      r_guard       <= 1'b0;
      r_frame_start <= 1'b0;
    end else begin
      r_hsync       <= HSyncPol ? w_hsync_on : ~w_hsync_on;
      r_vsync       <= VSyncPol ? w_vsync_on : ~w_vsync_on;
      r_de          <= w_de;
      r_x           <= w_de ? XW'(r_h_cnt) : '0;
      r_y           <= w_de ? YW'(r_v_cnt) : '0;
      r_preamble    <= w_preamble;
      r_guard       <= w_guard;
      r_frame_start <= w_frame_start;
    end
  end

  assign vid.hsync        = r_hsync;
  assign vid.vsync        = r_vsync;
  assign vid.de           = r_de;
  assign vid.x            = r_x;
  assign vid.y            = r_y;
  assign vid.vid_preamble = r_preamble;
  assign vid.vid_guard    = r_guard;
  assign vid.frame_start  = r_frame_start;

`ifdef H14TX_TIMINGS_DI_EN
  localparam int unsigned IslStart = HActive + 4;

  // Island: 8 preamble, 2 guard, 32 data, 2 guard, plus 4 control periods ahead of it.
  if (HBlank < 62) begin : g_bad_island
    $error("h14tx_timings: horizontal blank shorter than 62 pixels with data islands");
  end

  logic w_isl_pre;
  logic w_isl_guard;
  logic w_isl_data;

  assign w_isl_pre   = (r_h_cnt >= HCW'(IslStart)) && (r_h_cnt <= HCW'(IslStart + 7));
  assign w_isl_guard = ((r_h_cnt >= HCW'(IslStart + 8))  && (r_h_cnt <= HCW'(IslStart + 9))) ||
                       ((r_h_cnt >= HCW'(IslStart + 42)) && (r_h_cnt <= HCW'(IslStart + 43)));
  assign w_isl_data  = (r_h_cnt >= HCW'(IslStart + 10)) && (r_h_cnt <= HCW'(IslStart + 41));

  logic r_isl_pre;
  logic r_isl_guard;
  logic r_isl_data;

  always_ff @(posedge pixel_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_isl_pre   <= 1'b0;
      r_isl_guard <= 1'b0;
      r_isl_data  <= 1'b0;
    end else begin
      r_isl_pre   <= w_isl_pre;
      r_isl_guard <= w_isl_guard;
      r_isl_data  <= w_isl_data;
    end
  end

  assign vid.island_preamble = r_isl_pre;
  assign vid.island_guard    = r_isl_guard;
  assign vid.island_data     = r_isl_data;
`endif

endmodule

// File: tb/tb_h14tx_timings.sv
// Bench for h14tx_timings: checkpoint table plus a per-cycle scoreboard against a raster model.
// Island checks are compiled in when H14TX_TIMINGS_DI_EN is defined.
module tb_h14tx_timings;

  typedef struct packed {
    logic       hs;
    logic       vs;
    logic       de;
    logic       pre;
    logic       gd;
    logic       fs;
    logic [3:0] x;
    logic [1:0] y;
  } exp_t;

  typedef struct {
    int   t;
    exp_t e;
  } vec_t;

  typedef struct packed {
    logic ip;
    logic ig;
    logic id;
    logic vp;
    logic vg;
  } di_t;

  logic pixel_clk = 1'b0;
  logic rst_n     = 1'b1;
  int   n_cmp     = 0;
  int   n_bad     = 0;

  always #5 pixel_clk = ~pixel_clk;

  h14tx_timings_if #(.XW(4), .YW(2)) if_a ();
  h14tx_timings_if #(.XW(4), .YW(2)) if_b ();

  h14tx_timings #(
    .HActive(16), .HFrontPorch(4), .HSync(4), .HBackPorch(8),
    .VActive(4), .VFrontPorch(1), .VSync(2), .VBackPorch(1),
    .HSyncPol(1'b1), .VSyncPol(1'b1)
  ) u_a (.pixel_clk(pixel_clk), .rst_n(rst_n), .vid(if_a));

  h14tx_timings #(
    .HActive(16), .HFrontPorch(4), .HSync(4), .HBackPorch(8),
    .VActive(4), .VFrontPorch(1), .VSync(2), .VBackPorch(1),
    .HSyncPol(1'b0), .VSyncPol(1'b0)
  ) u_b (.pixel_clk(pixel_clk), .rst_n(rst_n), .vid(if_b));

`ifdef H14TX_TIMINGS_DI_EN
  h14tx_timings_if #(.XW(4), .YW(2)) if_c ();

  h14tx_timings #(
    .HActive(16), .HFrontPorch(20), .HSync(20), .HBackPorch(30),
    .VActive(4), .VFrontPorch(1), .VSync(2), .VBackPorch(1),
    .HSyncPol(1'b1), .VSyncPol(1'b1)
  ) u_c (.pixel_clk(pixel_clk), .rst_n(rst_n), .vid(if_c));

  di_t qc[$];

  function automatic di_t grab_c();
    di_t d;
    d.ip = if_c.island_preamble;
    d.ig = if_c.island_guard;
    d.id = if_c.island_data;
    d.vp = if_c.vid_preamble;
    d.vg = if_c.vid_guard;
    return d;
  endfunction

  // HTotal = 86: island 20..27 / 28..29 / 30..61 / 62..63, video preamble 76..83, guard 84..85.
  function automatic di_t model_c(int t);
    di_t d;
    int  h;
    int  v;
    bit  na;
    h    = t % 86;
    v    = (t / 86) % 8;
    na   = (v == 7) || (v < 3);
    d.ip = (h >= 20) && (h <= 27);
    d.ig = ((h >= 28) && (h <= 29)) || ((h >= 62) && (h <= 63));
    d.id = (h >= 30) && (h <= 61);
    d.vp = (h >= 76) && (h <= 83) && na;
    d.vg = (h >= 84) && na;
    return d;
  endfunction

  task automatic check_c(string name, di_t act, di_t req, int t);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s t=%0d actual=%b required=%b", name, t, act, req);
    end
  endtask
`endif

  exp_t q[$];
  int   tq[$];
  int   mt = 0;

  function automatic exp_t grab_a();
    exp_t e;
    e.hs = if_a.hsync;  e.vs = if_a.vsync;  e.de = if_a.de;
    e.pre = if_a.vid_preamble;  e.gd = if_a.vid_guard;  e.fs = if_a.frame_start;
    e.x = if_a.x;  e.y = if_a.y;
    return e;
  endfunction

  function automatic exp_t grab_b();
    exp_t e;
    e.hs = if_b.hsync;  e.vs = if_b.vsync;  e.de = if_b.de;
    e.pre = if_b.vid_preamble;  e.gd = if_b.vid_guard;  e.fs = if_b.frame_start;
    e.x = if_b.x;  e.y = if_b.y;
    return e;
  endfunction

  function automatic exp_t mk(bit hs, bit vs, bit de, bit pre, bit gd, bit fs, int x, int y);
    exp_t e;
    e.hs = hs;  e.vs = vs;  e.de = de;  e.pre = pre;  e.gd = gd;  e.fs = fs;
    e.x = 4'(x);  e.y = 2'(y);
    return e;
  endfunction

  // Base raster: 32 x 8, active 16 x 4, hsync 20..23, vsync lines 5..6.
  function automatic exp_t model(int t);
    int h;
    int v;
    bit na;
    bit de;
    h  = t % 32;
    v  = (t / 32) % 8;
    na = (v == 7) || (v < 3);
    de = (h < 16) && (v < 4);
    return mk((h >= 20) && (h <= 23), (v == 5) || (v == 6), de,
              (h >= 22) && (h <= 29) && na, (h >= 30) && na, (t % 256) == 0,
              de ? h : 0, de ? v : 0);
  endfunction

  function automatic exp_t inv_sync(exp_t e);
    exp_t r;
    r    = e;
    r.hs = ~e.hs;
    r.vs = ~e.vs;
    return r;
  endfunction

  task automatic check(string name, exp_t act, exp_t req, int t);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s t=%0d actual=%h required=%h", name, t, act, req);
    end
  endtask

  // Scoreboard producer: one expected record per edge while out of reset.
  initial forever begin
    @(posedge pixel_clk);
    if (!rst_n) begin
      mt = 0;
    end else begin
      q.push_back(model(mt));
      tq.push_back(mt);
`ifdef H14TX_TIMINGS_DI_EN
      qc.push_back(model_c(mt));
`endif
      mt++;
    end
  end

  // Scoreboard consumer: compare on the falling edge, away from the update edge.
  initial forever begin
    @(negedge pixel_clk);
    if (rst_n && q.size() > 0) begin
      exp_t e;
      int   t;
      e = q.pop_front();
      t = tq.pop_front();
      check("stream_a", grab_a(), e, t);
      check("stream_b", grab_b(), inv_sync(e), t);
`ifdef H14TX_TIMINGS_DI_EN
      check_c("stream_c", grab_c(), qc.pop_front(), t);
`endif
    end
  end

  vec_t tbl[23];
  exp_t rst_a;
  exp_t rst_b;

  initial begin
    int k;
    tbl[0]  = '{0,   mk(0, 0, 1, 0, 0, 1, 0, 0)};
    tbl[1]  = '{15,  mk(0, 0, 1, 0, 0, 0, 15, 0)};
    tbl[2]  = '{16,  mk(0, 0, 0, 0, 0, 0, 0, 0)};
    tbl[3]  = '{19,  mk(0, 0, 0, 0, 0, 0, 0, 0)};
    tbl[4]  = '{20,  mk(1, 0, 0, 0, 0, 0, 0, 0)};
    tbl[5]  = '{22,  mk(1, 0, 0, 1, 0, 0, 0, 0)};
    tbl[6]  = '{23,  mk(1, 0, 0, 1, 0, 0, 0, 0)};
    tbl[7]  = '{24,  mk(0, 0, 0, 1, 0, 0, 0, 0)};
    tbl[8]  = '{29,  mk(0, 0, 0, 1, 0, 0, 0, 0)};
    tbl[9]  = '{30,  mk(0, 0, 0, 0, 1, 0, 0, 0)};
    tbl[10] = '{31,  mk(0, 0, 0, 0, 1, 0, 0, 0)};
    tbl[11] = '{37,  mk(0, 0, 1, 0, 0, 0, 5, 1)};
    tbl[12] = '{127, mk(0, 0, 0, 0, 0, 0, 0, 0)};
    tbl[13] = '{152, mk(0, 0, 0, 0, 0, 0, 0, 0)};
    tbl[14] = '{159, mk(0, 0, 0, 0, 0, 0, 0, 0)};
    tbl[15] = '{160, mk(0, 1, 0, 0, 0, 0, 0, 0)};
    tbl[16] = '{180, mk(1, 1, 0, 0, 0, 0, 0, 0)};
    tbl[17] = '{223, mk(0, 1, 0, 0, 0, 0, 0, 0)};
    tbl[18] = '{224, mk(0, 0, 0, 0, 0, 0, 0, 0)};
    tbl[19] = '{246, mk(1, 0, 0, 1, 0, 0, 0, 0)};
    tbl[20] = '{254, mk(0, 0, 0, 0, 1, 0, 0, 0)};
    tbl[21] = '{255, mk(0, 0, 0, 0, 1, 0, 0, 0)};
    tbl[22] = '{256, mk(0, 0, 1, 0, 0, 1, 0, 0)};
    rst_a = mk(0, 0, 0, 0, 0, 0, 0, 0);
    rst_b = mk(1, 1, 0, 0, 0, 0, 0, 0);

    #3 rst_n = 1'b0;
    repeat (3) @(posedge pixel_clk);
    #1;
    check("reset_a", grab_a(), rst_a, -1);
    check("reset_b", grab_b(), rst_b, -1);
`ifdef H14TX_TIMINGS_DI_EN
    check_c("reset_c", grab_c(), '0, -1);
`endif
    @(negedge pixel_clk);
    #1 rst_n = 1'b1;

    k = -1;
    for (int i = 0; i < 23; i++) begin
      repeat (tbl[i].t - k) @(posedge pixel_clk);
      k = tbl[i].t;
      #1;
      check("tbl", grab_a(), tbl[i].e, tbl[i].t);
    end

    // Line 2, h 10 of the second frame: async reset mid-cycle.
    repeat (330 - k) @(posedge pixel_clk);
    #2;
    q.delete();
    tq.delete();
`ifdef H14TX_TIMINGS_DI_EN
    qc.delete();
`endif
    rst_n = 1'b0;
    #1;
    check("midreset_a", grab_a(), rst_a, 330);
    check("midreset_b", grab_b(), rst_b, 330);
`ifdef H14TX_TIMINGS_DI_EN
    check_c("midreset_c", grab_c(), '0, 330);
`endif
    repeat (2) @(posedge pixel_clk);
    #1;
    check("held_a", grab_a(), rst_a, -1);
    @(negedge pixel_clk);
    #1 rst_n = 1'b1;
    @(posedge pixel_clk);
    #1;
    check("restart_a", grab_a(), mk(0, 0, 1, 0, 0, 1, 0, 0), 0);
    check("restart_b", grab_b(), mk(1, 1, 1, 0, 0, 1, 0, 0), 0);
    repeat (700) @(posedge pixel_clk);
    @(negedge pixel_clk);
    #1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
